// File: rtl/riscv_pkg.sv
// Shared types for the fetch/data memory arbiter: FSM states, request sources, timeout counter width.
// Pure declarations; no latency or backpressure of its own.
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2,
    RESP     = 2'd3
  } arb_state_t;

  typedef enum logic {
    SRC_IF = 1'b0,
    SRC_D  = 1'b1
  } arb_src_t;

  localparam int TMO_CNT_W = 16;

  function automatic arb_src_t other_src(input arb_src_t s);
    return (s == SRC_IF) ? SRC_D : SRC_IF;
  endfunction

endpackage

// File: rtl/arb_prio_select.sv
// Combinational winner pick between fetch and data requests; on contention the source not granted last wins.
// Zero latency, no state, no backpressure of its own.
module arb_prio_select
  import riscv_pkg::*;
(
  input  logic if_req,
  input  logic d_req,
  input  logic last_src,
  output logic winner
);

  always_comb begin
    winner = SRC_D;
    if (if_req && d_req) begin
      winner = other_src(arb_src_t'(last_src));
    end else if (if_req) begin
      winner = SRC_IF;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and data; MEM_ARB_RR_EN selects round-robin on contention.
// Min latency req->gnt 2 cycles, req->rvalid 3; stalls in ISSUE while mem_gnt is low, times out after TIMEOUT_CYC in WAIT_RSP.
module mem_arbiter
  import riscv_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_err,

  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_err,

  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam logic [TMO_CNT_W-1:0] TMO_LIMIT = TMO_CNT_W'(TIMEOUT_CYC);

  arb_state_t           state;
  arb_src_t             src;
  logic [TMO_CNT_W-1:0] tmo_cnt;
  logic [TMO_CNT_W-1:0] tmo_next;
  logic                 last_bit;
  logic                 win_bit;
  arb_src_t             win_src;
  logic                 rsp_done;
  logic                 rsp_err;
  logic [DATA_W-1:0]    rsp_dat;

`ifdef MEM_ARB_RR_EN
  arb_src_t last_src;
  assign last_bit = last_src;
`else
  // Pinning "last granted" to fetch makes every contention resolve to data.
  assign last_bit = SRC_IF;
`endif

  arb_prio_select u_prio (
    .if_req   (if_req),
    .d_req    (d_req),
    .last_src (last_bit),
    .winner   (win_bit)
  );

  assign win_src  = arb_src_t'(win_bit);
  assign tmo_next = tmo_cnt + 1'b1;

  // A real response in the final timeout cycle still wins over the timeout.
  assign rsp_done = mem_rvalid || (tmo_next == TMO_LIMIT);
  assign rsp_err  = !mem_rvalid;
  assign rsp_dat  = mem_rvalid ? mem_rdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      src       <= SRC_IF;
      tmo_cnt   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      if_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      if_err    <= 1'b0;
      d_gnt     <= 1'b0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
      d_err     <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_src  <= SRC_IF;
`endif
    end else begin
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if_err    <= 1'b0;
      d_err     <= 1'b0;

      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            state   <= ISSUE;
            src     <= win_src;
            mem_req <= 1'b1;
`ifdef MEM_ARB_RR_EN
            last_src <= win_src;
`endif
            if (win_src == SRC_D) begin
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              mem_wstrb <= d_wstrb;
            end else begin
              mem_we    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
              mem_wstrb <= '0;
            end
          end
        end

        ISSUE: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= WAIT_RSP;
            if (src == SRC_D) d_gnt  <= 1'b1;
            else              if_gnt <= 1'b1;
          end
        end

        WAIT_RSP: begin
          if (rsp_done) begin
            state   <= RESP;
            tmo_cnt <= '0;
            if (src == SRC_D) begin
              d_rvalid <= 1'b1;
              d_rdata  <= rsp_dat;
              d_err    <= rsp_err;
            end else begin
              if_rvalid <= 1'b1;
              if_rdata  <= rsp_dat;
              if_err    <= rsp_err;
            end
          end else begin
            tmo_cnt <= tmo_next;
          end
        end

        RESP: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural memory, response scoreboard, one task per scenario.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  typedef struct {
    logic        is_d;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   gnt_delay = 0;
  int   rsp_delay = 0;
  bit   rsp_en    = 1'b1;

  mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(4)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
    return a ^ 32'hA5A5_0000;
  endfunction

  // Behavioural memory: grant after gnt_delay cycles of mem_req, respond rsp_delay cycles later.
  initial begin : mem_model
    logic [31:0] a;
    logic        w;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && mem_req === 1'b1) begin
        a = mem_addr;
        w = mem_we;
        repeat (gnt_delay) @(negedge clk);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        if (rsp_en) begin
          repeat (rsp_delay) @(negedge clk);
          mem_rvalid = 1'b1;
          mem_rdata  = w ? 32'h0 : mem_data(a);
          @(negedge clk);
          mem_rvalid = 1'b0;
          mem_rdata  = '0;
        end
      end
    end
  end

  initial begin : rsp_monitor
    rsp_t        e;
    logic        got_d;
    logic [31:0] got_dat;
    logic        got_err;
    forever begin
      @(negedge clk);
      if (if_rvalid === 1'b1 || d_rvalid === 1'b1) begin
        n_checks++;
        got_d   = (d_rvalid === 1'b1);
        got_dat = got_d ? d_rdata : if_rdata;
        got_err = got_d ? d_err : if_err;
        if (if_rvalid === 1'b1 && d_rvalid === 1'b1) begin
          n_fail++;
          $display("FAIL rsp_both: if_rvalid=%b d_rvalid=%b, required only one", if_rvalid, d_rvalid);
        end else if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rsp_unexpected: src_d=%b data=%h err=%b, required no response", got_d, got_dat, got_err);
        end else begin
          e = exp_q.pop_front();
          if (got_d !== e.is_d || got_dat !== e.rdata || got_err !== e.err) begin
            n_fail++;
            $display("FAIL rsp_data: src_d=%b data=%h err=%b, required src_d=%b data=%h err=%b",
                     got_d, got_dat, got_err, e.is_d, e.rdata, e.err);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic push_exp(input logic is_d, input logic [31:0] dat, input logic err);
    rsp_t e;
    e.is_d = is_d; e.rdata = dat; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d responses outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic drive_d(input logic [31:0] a, input logic we, output int gnt_cyc);
    int k;
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = ~a; d_wstrb = 4'hF;
    k = 0;
    do begin @(negedge clk); k++; end while (d_gnt !== 1'b1 && k < 100);
    n_checks++;
    if (d_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL d_gnt_wait: d_gnt=%b after %0d cycles, required 1", d_gnt, k);
    end
    d_req = 1'b0; d_we = 1'b0;
    gnt_cyc = k;
  endtask

  task automatic drive_if(input logic [31:0] a);
    int k;
    if_req = 1'b1; if_addr = a;
    k = 0;
    do begin @(negedge clk); k++; end while (if_gnt !== 1'b1 && k < 100);
    n_checks++;
    if (if_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL if_gnt_wait: if_gnt=%b after %0d cycles, required 1", if_gnt, k);
    end
    if_req = 1'b0;
  endtask

  task automatic wait_rvalid(input logic is_d);
    int k;
    k = 0;
    do begin @(negedge clk); k++; end
    while ((is_d ? d_rvalid : if_rvalid) !== 1'b1 && k < 100);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({mem_req, mem_we, mem_wstrb, if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl: ctrl=%b, required all 0",
               {mem_req, mem_we, mem_wstrb, if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err});
    end
    n_checks++;
    if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: addr=%h wdata=%h if_rdata=%h d_rdata=%h, required 0",
               mem_addr, mem_wdata, if_rdata, d_rdata);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_data_write();
    push_exp(1'b1, 32'h0, 1'b0);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'h1234_5678; d_wstrb = 4'hF;
    @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h2000 ||
        mem_wdata !== 32'h1234_5678 || mem_wstrb !== 4'hF) begin
      n_fail++;
      $display("FAIL write_fields: req=%b we=%b addr=%h wdata=%h wstrb=%h, required 1 1 2000 12345678 f",
               mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb);
    end
    @(negedge clk);
    n_checks++;
    if (d_gnt !== 1'b1 || if_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL write_gnt: d_gnt=%b if_gnt=%b, required 1 0", d_gnt, if_gnt);
    end
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    n_checks++;
    if (d_rvalid !== 1'b1 || if_rvalid !== 1'b0 || if_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL write_ack: d_rvalid=%b if_rvalid=%b if_gnt=%b, required 1 0 0", d_rvalid, if_rvalid, if_gnt);
    end
    wait_drain("write");
  endtask

  task automatic test_single_fetch();
    push_exp(1'b0, 32'hDEAD_BEEF, 1'b0);
    if_req = 1'b1; if_addr = 32'h100;
    @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0 || mem_wstrb !== 4'h0) begin
      n_fail++;
      $display("FAIL fetch_issue: req=%b addr=%h we=%b wstrb=%h, required 1 100 0 0",
               mem_req, mem_addr, mem_we, mem_wstrb);
    end
    @(negedge clk);
    n_checks++;
    if (if_gnt !== 1'b1 || d_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_gnt_cyc2: if_gnt=%b d_gnt=%b, required 1 0", if_gnt, d_gnt);
    end
    if_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (if_rvalid !== 1'b1 || if_rdata !== 32'hDEAD_BEEF || if_err !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_rvalid_cyc3: rvalid=%b rdata=%h err=%b, required 1 deadbeef 0",
               if_rvalid, if_rdata, if_err);
    end
    wait_drain("fetch");
  endtask

  task automatic test_contention();
    int g;
`ifdef MEM_ARB_RR_EN
    push_exp(1'b1, mem_data(32'h3100), 1'b0);
    push_exp(1'b0, mem_data(32'h0200), 1'b0);
    push_exp(1'b1, mem_data(32'h3104), 1'b0);
    push_exp(1'b0, mem_data(32'h0204), 1'b0);
`else
    push_exp(1'b1, mem_data(32'h3100), 1'b0);
    push_exp(1'b1, mem_data(32'h3104), 1'b0);
    push_exp(1'b0, mem_data(32'h0200), 1'b0);
    push_exp(1'b0, mem_data(32'h0204), 1'b0);
`endif
    fork
      begin
        drive_d(32'h3100, 1'b0, g);
        wait_rvalid(1'b1);
        drive_d(32'h3104, 1'b0, g);
      end
      begin
        drive_if(32'h0200);
        wait_rvalid(1'b0);
        drive_if(32'h0204);
      end
    join
    wait_drain("contention");
  endtask

  task automatic test_backpressure();
    int k;
    gnt_delay = 10;
    push_exp(1'b1, mem_data(32'h3000), 1'b0);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000; d_wdata = 32'h0; d_wstrb = 4'h0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h3000 || mem_we !== 1'b0 || d_gnt !== 1'b0 || if_gnt !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: req=%b addr=%h we=%b d_gnt=%b if_gnt=%b, required 1 3000 0 0 0",
                 i, mem_req, mem_addr, mem_we, d_gnt, if_gnt);
      end
    end
    k = 10;
    do begin @(negedge clk); k++; end while (d_gnt !== 1'b1 && k < 40);
    d_req = 1'b0;
    n_checks++;
    if (k !== 12) begin
      n_fail++;
      $display("FAIL bp_gnt_cycle: d_gnt at cycle %0d, required 12", k);
    end
    gnt_delay = 0;
    wait_drain("backpressure");
  endtask

  task automatic test_timeout();
    int g;
    int k;
    rsp_en = 1'b0;
    push_exp(1'b1, 32'h0, 1'b1);
    drive_d(32'h4000, 1'b0, g);
    mem_rdata = 32'hFFFF_FFFF;
    k = 0;
    do begin @(negedge clk); k++; end while (d_rvalid !== 1'b1 && k < 40);
    n_checks++;
    if (k !== 4 || d_err !== 1'b1 || d_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL timeout_rsp: after %0d cycles err=%b rdata=%h, required 4 1 0", k, d_err, d_rdata);
    end
    @(negedge clk);
    mem_rvalid = 1'b1;
    mem_gnt    = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_gnt    = 1'b0;
    mem_rdata  = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (d_rvalid !== 1'b0 || if_rvalid !== 1'b0 || d_gnt !== 1'b0 || if_gnt !== 1'b0 || mem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL stray_ignored_%0d: d_rv=%b if_rv=%b d_gnt=%b if_gnt=%b mem_req=%b, required all 0",
                 i, d_rvalid, if_rvalid, d_gnt, if_gnt, mem_req);
      end
    end
    rsp_en = 1'b1;
    wait_drain("timeout");
  endtask

  task automatic test_reset_mid();
    int g;
    rsp_en = 1'b0;
    drive_d(32'h5000, 1'b0, g);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || d_rvalid !== 1'b0 || d_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: mem_req=%b d_rvalid=%b d_gnt=%b, required 0 0 0", mem_req, d_rvalid, d_gnt);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++;
      if (d_rvalid !== 1'b0 || if_rvalid !== 1'b0 || mem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_mid_quiet_%0d: d_rvalid=%b if_rvalid=%b mem_req=%b, required 0 0 0",
                 i, d_rvalid, if_rvalid, mem_req);
      end
    end
    rsp_en = 1'b1;
    push_exp(1'b0, mem_data(32'h600), 1'b0);
    drive_if(32'h600);
    wait_drain("rst_mid_fetch");
  endtask

  initial begin : main
    test_reset();
    test_data_write();
    test_single_fetch();
    test_contention();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL final_queue: %0d entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; DATA_W/8 strobe bits.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 255, max cycles waiting for mem_rvalid; legal range 1..65535.
REQ-004 SHALL have ports: clk  in  1  sole clock, rising edge; rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have fetch ports: if_req in 1 request; if_addr in ADDR_W address; if_gnt out 1 accept pulse; if_rvalid out 1 response pulse; if_rdata out DATA_W read data; if_err out 1 timeout flag, valid with if_rvalid.
REQ-006 SHALL have data ports: d_req in 1; d_we in 1 write enable; d_addr in ADDR_W; d_wdata in DATA_W; d_wstrb in DATA_W/8; d_gnt out 1; d_rvalid out 1; d_rdata out DATA_W; d_err out 1.
REQ-007 SHALL have memory ports: mem_req out 1; mem_we out 1; mem_addr out ADDR_W; mem_wdata out DATA_W; mem_wstrb out DATA_W/8; mem_gnt in 1 accept; mem_rvalid in 1 response (reads and write acks); mem_rdata in DATA_W.

Function
REQ-008 SHALL share one single-ported memory between fetch and data requesters, one transaction outstanding at a time.
REQ-009 SHALL implement FSM states IDLE, ISSUE, WAIT_RSP, RESP.
REQ-010 IDLE: on any req, SHALL latch winner's fields and source, go ISSUE next cycle; no req -> stay IDLE.
REQ-011 ISSUE: SHALL drive mem_req=1 with latched fields; on mem_gnt=1 SHALL pulse winner's *_gnt one cycle (registered, next cycle) and go WAIT_RSP.
REQ-012 WAIT_RSP: on mem_rvalid=1 SHALL register mem_rdata, go RESP; timeout counter increments per cycle.
REQ-013 RESP: SHALL pulse winner's *_rvalid one cycle with *_rdata, *_err; go IDLE.
REQ-014 Minimum latency: req at cycle 0, mem_gnt at 1, mem_rvalid at 2 -> *_gnt at 2, *_rvalid at 3, next req accepted at 3.
REQ-015 Requester SHALL hold req and fields stable until its *_gnt; arbiter samples fields only in IDLE.
REQ-016 Simultaneous if_req and d_req in IDLE: d wins (default priority, see REQ-021).
REQ-017 mem_rvalid outside WAIT_RSP SHALL be ignored; mem_gnt outside ISSUE SHALL be ignored.
REQ-018 Timeout: counter reaching TIMEOUT_CYC in WAIT_RSP SHALL go RESP with *_err=1, *_rdata=0; counter clears on leaving WAIT_RSP.
REQ-019 Non-winner *_gnt, *_rvalid SHALL stay 0; mem_we, mem_wstrb SHALL be 0 for fetch transactions.

Reset
REQ-020 rst=1 SHALL asynchronously force IDLE, all outputs 0, counter 0, last-grant pointer = fetch; in-flight transaction discarded, no response issued.

Configuration
REQ-021 Macro MEM_ARB_RR_EN: defined -> round-robin on simultaneous requests, winner is the source not granted last (pointer updated in IDLE on grant); undefined -> fixed data-over-fetch priority, pointer absent.

Structure
REQ-022 riscv_pkg SHALL hold arb_state_t (IDLE, ISSUE, WAIT_RSP, RESP) and arb_src_t (SRC_IF, SRC_D).
REQ-023 Priority choice SHALL be a sub-module arb_prio_select (combinational, inputs if_req, d_req, last source; output winner).

Verification
REQ-024 Single fetch: if_req, addr 0x100, mem_gnt immediate, mem_rvalid next with 0xDEADBEEF -> if_gnt cycle 2, if_rvalid cycle 3, if_rdata 0xDEADBEEF, if_err 0.
REQ-025 Data write: d_we=1, addr 0x2000, wdata 0x12345678, wstrb 0xF -> mem_we=1, fields match, d_rvalid pulse after ack, no if_* activity.
REQ-026 Contention: if_req and d_req both held -> default build serves d then if; MEM_ARB_RR_EN build with repeated requests alternates d, if, d, if.
REQ-027 Timeout: TIMEOUT_CYC=4, mem_rvalid never asserts -> d_rvalid=1, d_err=1, d_rdata=0 after 4 WAIT_RSP cycles; later stray mem_rvalid ignored.
REQ-028 Reset mid-transaction: rst in WAIT_RSP -> immediate mem_req=0, state IDLE, no *_rvalid; fresh if_req afterwards completes normally.
REQ-029 Backpressure: mem_gnt low 10 cycles in ISSUE -> mem_req and fields held stable, no *_gnt until mem_gnt.
